time_set_ctrl: RTL
==================

Name: time_set_ctrl

Overview:
- Button-driven time-setting controller; the producer end of the set interface of hour_counter and the minute bcd_counter pair.
- Loads the running time and lets the user edit hours, then minutes, with two buttons.
- On commit, drives set, the BCD digits and the AM/PM flag, held long enough for the slow sec_clk-triggered counters to sample them.
- Sits between the debounced pushbutton inputs and the clock counters.

Parameters:
- SET_HOLD, default 2: number of clk cycles set stays high after commit (minimum 1).
- EDIT_TIMEOUT, default 1000: idle clk cycles in an edit state before the edit aborts without commit (minimum 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_mode  in  1  debounced level, synchronous to clk; rising edge = mode press.
- btn_inc  in  1  debounced level, synchronous to clk; rising edge = increment press.
- mode_12h  in  1  1 = 12-hour format, 0 = 24-hour format.
- cur_h1, cur_h0, cur_m1, cur_m0  in  4 each  running-time BCD digits.
- cur_pm  in  1  running AM/PM flag (12h mode only).
- set  out  1  commit strobe, held SET_HOLD cycles.
- set_h1, set_h0, set_m1, set_m0  out  4 each  edited BCD digits; continuously reflect the edit registers.
- set_am_pm  out  1  edited PM flag; forced 0 in 24h mode.
- editing  out  2  00 idle, 01 editing hours, 10 editing minutes, 11 committing (for display blink).

Behaviour:
- Reset: state IDLE; set=0; all digits 0; set_am_pm=0; editing=00; timeout and hold counters 0; edge registers 0.
- Edge detection: press = btn & ~btn_q. A press acts on the same clk edge at which it is detected; outputs show the effect one cycle later.
- Simultaneous presses: mode wins; inc is ignored that cycle.
- A held button gives exactly one press.
- IDLE + mode press: go to EDIT_H.
  - Load edit registers from cur_*.
  - Latch mode_12h into mode_q.
  - Invalid cur values are replaced: hour >23 (24h) becomes 00; hour outside 01..12 (12h) becomes 12 AM; minute >59 becomes 00.
- IDLE + inc press: ignored.
- EDIT_H + inc:
  - 24h mode: 00..23, 23 wraps to 00.
  - 12h mode: 01..12, 12 wraps to 01.
  - 12h mode: stepping 11 to 12 toggles pm.
  - BCD carry: x9 steps to (x+1)0.
- EDIT_H + mode press: go to EDIT_M.
- EDIT_M + inc: 00..59, 59 wraps to 00; hours untouched.
- EDIT_M + mode press: go to COMMIT.
- COMMIT:
  - set=1 for exactly SET_HOLD cycles, starting the cycle after entry.
  - Digits stay stable throughout the hold and afterwards.
  - Then return to IDLE with set=0.
  - Presses during COMMIT are ignored.
- Timeout:
  - The counter clears on entry to each edit state and on every press.
  - When it reaches EDIT_TIMEOUT in EDIT_H or EDIT_M, go to IDLE; set is never asserted.
- mode_12h change during EDIT_H or EDIT_M (mode_12h != mode_q): abort to IDLE next cycle with no commit.
- rst in any state, including mid-COMMIT: the next cycle equals the reset state, and set drops immediately.

Decomposition:
- clock_pkg:
  - State enum (IDLE, EDIT_H, EDIT_M, COMMIT).
  - editing code constants.
  - BCD limit constants (HOUR24_MAX=23, HOUR12_MIN=1, HOUR12_MAX=12, MIN_MAX=59).
- Sub-module btn_edge: registered rising-edge detector with clk/rst, instantiated for btn_mode and btn_inc.
- Hour and minute BCD increment logic stays inline.

Test Plan:
- 24h edit: cur 14:37; mode, inc x3, mode, inc x2, mode -> set high 2 cycles; set_h1/h0=1/7, set_m1/m0=3/9, set_am_pm=0; editing returns to 00.
- Hour wraps: 24h from 22, inc x2 -> 00. 12h from 11 AM, inc -> 12 PM, inc -> 01 PM. Minute 58, inc x2 -> 00.
- Timeout, with EDIT_TIMEOUT=20: enter EDIT_H, no presses for 20 cycles -> IDLE, set never asserted, editing=00.
- Simultaneous mode+inc in EDIT_H -> goes to EDIT_M, hour unchanged; button held 50 cycles -> single increment only.
- Abort cases:
  - Toggle mode_12h in EDIT_M -> IDLE, no set.
  - rst during the COMMIT hold -> set=0 and all digits 0 the next cycle.
- Invalid load: cur hour 1/9 (19) with mode_12h=1 -> edit starts at 12 AM; cur minute 7/2 (72) -> 00.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the time-setting controller and its
// BCD hour/minute editing logic.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EDIT_H = 2'b01,
    EDIT_M = 2'b10,
    COMMIT = 2'b11
  } state_t;

  localparam logic [1:0] EDIT_CODE_IDLE   = 2'b00;
  localparam logic [1:0] EDIT_CODE_HOUR   = 2'b01;
  localparam logic [1:0] EDIT_CODE_MIN    = 2'b10;
  localparam logic [1:0] EDIT_CODE_COMMIT = 2'b11;

  localparam int HOUR24_MAX = 23;
  localparam int HOUR12_MIN = 1;
  localparam int HOUR12_MAX = 12;
  localparam int MIN_MAX    = 59;

  function automatic int bcd_value(input logic [3:0] tens, input logic [3:0] ones);
    return int'(tens) * 10 + int'(ones);
  endfunction

  // A two-digit BCD pair is usable only if the ones digit is a real BCD
  // digit and the combined value lies in [lo, hi].
  function automatic logic bcd_in_range(input logic [3:0] tens, input logic [3:0] ones,
                                        input int lo, input int hi);
    int v;
    v = bcd_value(tens, ones);
    return (ones <= 4'd9) && (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for a debounced, clk-synchronous button.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
    end
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Two-button time editor: loads the running time, edits hours then minutes,
// and presents a held set strobe to the slow BCD time counters on commit.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int SET_HOLD     = 2,
  parameter int EDIT_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       mode_12h,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  input  logic       cur_pm,
  output logic       set,
  output logic [3:0] set_h1,
  output logic [3:0] set_h0,
  output logic [3:0] set_m1,
  output logic [3:0] set_m0,
  output logic       set_am_pm,
  output logic [1:0] editing
);

  localparam int TMO_W  = $clog2(EDIT_TIMEOUT + 1);
  localparam int HOLD_W = $clog2(SET_HOLD + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(EDIT_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SET_HOLD - 1);

  logic [1:0] btn_vec;
  logic [1:0] press_vec;
  logic       mode_press;
  logic       inc_press;

  assign btn_vec = {btn_inc, btn_mode};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_edge
      btn_edge u_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_vec[gi]),
        .press (press_vec[gi])
      );
    end
  endgenerate

  assign mode_press = press_vec[0];
  assign inc_press  = press_vec[1];

  state_t            state_reg;
  logic [3:0]        h1_reg, h0_reg, m1_reg, m0_reg;
  logic              pm_reg;
  logic              mode_q;
  logic [TMO_W-1:0]  tmo_cnt_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              set_reg;
  logic [1:0]        editing_reg;

  // Sanitised load values from the running time.
  logic [3:0] load_h1, load_h0, load_m1, load_m0;
  logic       load_pm;

  always_comb begin
    load_h1 = cur_h1;
    load_h0 = cur_h0;
    load_pm = mode_12h & cur_pm;
    if (mode_12h) begin
      if (!bcd_in_range(cur_h1, cur_h0, HOUR12_MIN, HOUR12_MAX)) begin
        load_h1 = 4'd1;
        load_h0 = 4'd2;
        load_pm = 1'b0;
      end
    end else begin
      if (!bcd_in_range(cur_h1, cur_h0, 0, HOUR24_MAX)) begin
        load_h1 = 4'd0;
        load_h0 = 4'd0;
      end
    end
    load_m1 = cur_m1;
    load_m0 = cur_m0;
    if (!bcd_in_range(cur_m1, cur_m0, 0, MIN_MAX)) begin
      load_m1 = 4'd0;
      load_m0 = 4'd0;
    end
  end

  // Next hour on an increment press; the range follows the latched format.
  logic [3:0] hinc_h1_next, hinc_h0_next;
  logic       hinc_pm_next;

  always_comb begin
    hinc_h1_next = h1_reg;
    hinc_h0_next = h0_reg + 4'd1;
    hinc_pm_next = pm_reg;
    if (mode_q) begin
      if (bcd_value(h1_reg, h0_reg) == HOUR12_MAX) begin
        hinc_h1_next = 4'd0;
        hinc_h0_next = 4'd1;
      end else if (bcd_value(h1_reg, h0_reg) == HOUR12_MAX - 1) begin
        hinc_h1_next = 4'd1;
        hinc_h0_next = 4'd2;
        hinc_pm_next = ~pm_reg;
      end else if (h0_reg == 4'd9) begin
        hinc_h1_next = h1_reg + 4'd1;
        hinc_h0_next = 4'd0;
      end
    end else begin
      if (bcd_value(h1_reg, h0_reg) == HOUR24_MAX) begin
        hinc_h1_next = 4'd0;
        hinc_h0_next = 4'd0;
      end else if (h0_reg == 4'd9) begin
        hinc_h1_next = h1_reg + 4'd1;
        hinc_h0_next = 4'd0;
      end
    end
  end

  logic [3:0] minc_m1_next, minc_m0_next;

  always_comb begin
    minc_m1_next = m1_reg;
    minc_m0_next = m0_reg + 4'd1;
    if (bcd_value(m1_reg, m0_reg) == MIN_MAX) begin
      minc_m1_next = 4'd0;
      minc_m0_next = 4'd0;
    end else if (m0_reg == 4'd9) begin
      minc_m1_next = m1_reg + 4'd1;
      minc_m0_next = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      h1_reg       <= 4'd0;
      h0_reg       <= 4'd0;
      m1_reg       <= 4'd0;
      m0_reg       <= 4'd0;
      pm_reg       <= 1'b0;
      mode_q       <= 1'b0;
      tmo_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      set_reg      <= 1'b0;
      editing_reg  <= EDIT_CODE_IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mode_press) begin
            h1_reg      <= load_h1;
            h0_reg      <= load_h0;
            m1_reg      <= load_m1;
            m0_reg      <= load_m0;
            pm_reg      <= load_pm;
            mode_q      <= mode_12h;
            tmo_cnt_reg <= '0;
            state_reg   <= EDIT_H;
            editing_reg <= EDIT_CODE_HOUR;
          end
        end
        EDIT_H: begin
          // A format change mid-edit would make the edited hour ambiguous.
          if (mode_12h != mode_q) begin
            state_reg   <= IDLE;
            editing_reg <= EDIT_CODE_IDLE;
          end else if (mode_press) begin
            tmo_cnt_reg <= '0;
            state_reg   <= EDIT_M;
            editing_reg <= EDIT_CODE_MIN;
          end else if (inc_press) begin
            h1_reg      <= hinc_h1_next;
            h0_reg      <= hinc_h0_next;
            pm_reg      <= hinc_pm_next;
            tmo_cnt_reg <= '0;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            state_reg   <= IDLE;
            editing_reg <= EDIT_CODE_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        EDIT_M: begin
          if (mode_12h != mode_q) begin
            state_reg   <= IDLE;
            editing_reg <= EDIT_CODE_IDLE;
          end else if (mode_press) begin
            hold_cnt_reg <= '0;
            set_reg      <= 1'b1;
            state_reg    <= COMMIT;
            editing_reg  <= EDIT_CODE_COMMIT;
          end else if (inc_press) begin
            m1_reg      <= minc_m1_next;
            m0_reg      <= minc_m0_next;
            tmo_cnt_reg <= '0;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            state_reg   <= IDLE;
            editing_reg <= EDIT_CODE_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        COMMIT: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            set_reg     <= 1'b0;
            state_reg   <= IDLE;
            editing_reg <= EDIT_CODE_IDLE;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          set_reg     <= 1'b0;
          editing_reg <= EDIT_CODE_IDLE;
        end
      endcase
    end
  end

  assign set       = set_reg;
  assign set_h1    = h1_reg;
  assign set_h0    = h0_reg;
  assign set_m1    = m1_reg;
  assign set_m0    = m0_reg;
  assign set_am_pm = pm_reg & mode_q;
  assign editing   = editing_reg;

endmodule
